// File: rtl/integration_pkg.sv
// Shared constants for the integration MAC: register map, CTRL/STATUS bit
// positions and the controller state type.
package integration_pkg;

    localparam logic [7:0] ADDR_A      = 8'd0;
    localparam logic [7:0] ADDR_B      = 8'd1;
    localparam logic [7:0] ADDR_CTRL   = 8'd2;
    localparam logic [7:0] ADDR_STATUS = 8'd3;
    localparam logic [7:0] ADDR_RESULT = 8'd4;

    localparam int CTRL_START = 0;
    localparam int CTRL_ACC   = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_OVF  = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    function automatic logic [2:0] pack_status(input logic busy, input logic done,
                                               input logic ovf);
        logic [2:0] s;
        s             = 3'b000;
        s[STAT_BUSY]  = busy;
        s[STAT_DONE]  = done;
        s[STAT_OVF]   = ovf;
        return s;
    endfunction

endpackage

// File: rtl/integration_mac_if.sv
// Bundle of the Avalon-MM slave and conduit signals of integration_mac.
// Handshake: write/read are single-cycle strobes with no waitrequest; readdata is valid one cycle after read.
interface integration_mac_if #(parameter int N = 32);

    logic [7:0]   address;
    logic         write;
    logic [N-1:0] writedata;
    logic         read;
    logic [N-1:0] readdata;
    logic [N-1:0] result;
    logic         done;
    logic         busy;

    modport master (
        output address, write, writedata, read,
        input  readdata, result, done, busy
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, result, done, busy
    );

endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: operands captured on start, then exactly N
// iterations of one multiplier bit per cycle, done pulses on the last one.
module seq_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [2*N-1:0] mcand;
    logic [N-1:0]   mplier;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                mcand   <= {{N{1'b0}}, a};
                mplier  <= b;
                product <= '0;
                cnt     <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                // Zero multiplier bits still cost a cycle: latency is data-independent.
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/integration_mac.sv
// Memory-mapped scaled multiply/accumulate: register decode, control FSM,
// scaling, accumulation and overflow flags around seq_multiplier.
module integration_mac
    import integration_pkg::*;
#(
    parameter int N        = 32,
    parameter int SCALE_SH = 1
) (
    input  logic         csi_clk,
    input  logic         rsi_rst_n,
    input  logic [7:0]   avs_s0_address,
    input  logic         avs_s0_write,
    input  logic [N-1:0] avs_s0_writedata,
    input  logic         avs_s0_read,
    output logic [N-1:0] avs_s0_readdata,
    output logic [N-1:0] coe_R,
    output logic         coe_done,
    output logic         coe_busy
);

    state_t         state;
    logic [N-1:0]   reg_a;
    logic [N-1:0]   reg_b;
    logic           work_acc;
    logic           done_flag;
    logic           ovf_flag;

    logic           mul_busy;
    logic           mul_done;
    logic [2*N-1:0] mul_product;

    logic           bus_open;
    logic           start_accept;
    logic [3*N-1:0] shifted;
    logic [N:0]     sum;
    logic           next_ovf;

    // The bus registers and CTRL are frozen for the whole CALC state.
    assign bus_open     = (state == ST_IDLE);
    assign start_accept = bus_open && !mul_busy && avs_s0_write &&
                          (avs_s0_address == ADDR_CTRL) && avs_s0_writedata[CTRL_START];

    assign shifted  = {{N{1'b0}}, mul_product} << SCALE_SH;
    assign sum      = {1'b0, (work_acc ? coe_R : {N{1'b0}})} + {1'b0, shifted[N-1:0]};
    assign next_ovf = (|shifted[3*N-1:N]) | sum[N];

    seq_multiplier #(.N(N)) u_mul (
        .clk     (csi_clk),
        .rst_n   (rsi_rst_n),
        .start   (start_accept),
        .a       (reg_a),
        .b       (reg_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            reg_a <= '0;
            reg_b <= '0;
        end else if (avs_s0_write && bus_open) begin
            if (avs_s0_address == ADDR_A) begin
                reg_a <= avs_s0_writedata;
            end
            if (avs_s0_address == ADDR_B) begin
                reg_b <= avs_s0_writedata;
            end
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            state     <= ST_IDLE;
            work_acc  <= 1'b0;
            done_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            coe_R     <= '0;
            coe_done  <= 1'b0;
            coe_busy  <= 1'b0;
        end else begin
            coe_done <= 1'b0;
            // Busy rises one edge after START is sampled and falls on the completion edge.
            coe_busy <= (state == ST_CALC) && !mul_done;
            case (state)
                ST_IDLE: begin
                    if (start_accept) begin
                        state     <= ST_CALC;
                        work_acc  <= avs_s0_writedata[CTRL_ACC];
                        done_flag <= 1'b0;
                    end
                end
                ST_CALC: begin
                    if (mul_done) begin
                        state     <= ST_IDLE;
                        coe_R     <= sum[N-1:0];
                        ovf_flag  <= next_ovf;
                        done_flag <= 1'b1;
                        coe_done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered read path: the value returned is the one before any same-cycle write.
    always_ff @(posedge csi_clk or negedge rsi_rst_n) begin
        if (!rsi_rst_n) begin
            avs_s0_readdata <= '0;
        end else if (avs_s0_read) begin
            case (avs_s0_address)
                ADDR_A:      avs_s0_readdata <= reg_a;
                ADDR_B:      avs_s0_readdata <= reg_b;
                ADDR_STATUS: avs_s0_readdata <= {{(N-3){1'b0}},
                                                 pack_status(coe_busy, done_flag, ovf_flag)};
                ADDR_RESULT: avs_s0_readdata <= coe_R;
                default:     avs_s0_readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_integration_mac.sv
// Self-checking bench for integration_mac (N=32, SCALE_SH=1): directed table,
// multi-cycle corner sequences and randomized operations against a reference model.
module tb_integration_mac;

  localparam int N = 32;
  localparam int SCALE_SH = 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    logic [31:0] exp_r;
    logic [2:0]  exp_status;
  } vec_t;

  logic csi_clk;
  logic rsi_rst_n;
  integration_mac_if #(.N(N)) bus ();

  int checks;
  int errors;
  int done_pulses;
  logic [31:0] model_prev;
  vec_t vecs[8];

  integration_mac #(.N(N), .SCALE_SH(SCALE_SH)) dut (
    .csi_clk          (csi_clk),
    .rsi_rst_n        (rsi_rst_n),
    .avs_s0_address   (bus.address),
    .avs_s0_write     (bus.write),
    .avs_s0_writedata (bus.writedata),
    .avs_s0_read      (bus.read),
    .avs_s0_readdata  (bus.readdata),
    .coe_R            (bus.result),
    .coe_done         (bus.done),
    .coe_busy         (bus.busy)
  );

  // clock / reset
  initial csi_clk = 1'b0;
  always #5 csi_clk = ~csi_clk;

  always @(negedge csi_clk) begin
    if (bus.done === 1'b1) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: scaled product in wide arithmetic, result modulo 2**32.
  function automatic logic [32:0] ref_mac(input logic [31:0] a, input logic [31:0] b,
                                          input logic acc, input logic [31:0] prev);
    logic [127:0] full;
    logic [127:0] base;
    logic [127:0] total;
    logic         ovf;
    full  = ({96'd0, a} * {96'd0, b}) * (128'd1 << SCALE_SH);
    base  = acc ? {96'd0, prev} : 128'd0;
    total = base + full;
    ovf   = (full >= (128'd1 << 32)) || ((base + {96'd0, full[31:0]}) >= (128'd1 << 32));
    return {ovf, total[31:0]};
  endfunction

  // driver tasks (entered and left at a falling edge)
  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    bus.address = addr;
    bus.writedata = data;
    bus.write = 1'b1;
    @(negedge csi_clk);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    bus.address = addr;
    bus.read = 1'b1;
    @(negedge csi_clk);
    bus.read = 1'b0;
    data = bus.readdata;
  endtask

  task automatic wait_done(input string tag);
    int edge_seen;
    int busy_bad;
    edge_seen = 0;
    busy_bad = 0;
    for (int i = 1; i <= N + 8; i++) begin
      @(negedge csi_clk);
      if (bus.busy !== ((i <= N) ? 1'b1 : 1'b0)) busy_bad++;
      if (bus.done === 1'b1) begin
        edge_seen = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(edge_seen), 64'(N + 1));
    check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
    @(negedge csi_clk);
    check({tag, "_done_one_cycle"}, 64'(bus.done), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic acc,
                        input string tag);
    bus_write(8'd0, a);
    bus_write(8'd1, b);
    bus_write(8'd2, {30'd0, acc, 1'b1});
    wait_done(tag);
  endtask

  initial begin
    logic [31:0] d;
    logic [32:0] m;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        racc;

    checks = 0;
    errors = 0;
    done_pulses = 0;
    model_prev = 32'd0;

    vecs[0] = '{32'd3,          32'd5,          1'b0, 32'd30,         3'b010};
    vecs[1] = '{32'd1,          32'd1,          1'b1, 32'd32,         3'b010};
    vecs[2] = '{32'h8000_0000,  32'd1,          1'b0, 32'd0,          3'b110};
    vecs[3] = '{32'd0,          32'hFFFF_FFFF,  1'b0, 32'd0,          3'b010};
    vecs[4] = '{32'h7FFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFE,  3'b010};
    vecs[5] = '{32'd1,          32'd1,          1'b1, 32'd0,          3'b110};
    vecs[6] = '{32'h0001_0000,  32'h0001_0000,  1'b0, 32'd0,          3'b110};
    vecs[7] = '{32'h0000_1234,  32'h0000_0010,  1'b0, 32'h0002_4680, 3'b010};

    rsi_rst_n = 1'b0;
    bus.address = 8'd0;
    bus.write = 1'b0;
    bus.writedata = 32'd0;
    bus.read = 1'b0;
    repeat (3) @(negedge csi_clk);
    rsi_rst_n = 1'b1;
    @(negedge csi_clk);

    // reset state
    check("rst_coe_R", 64'(bus.result), 64'd0);
    check("rst_coe_done", 64'(bus.done), 64'd0);
    check("rst_coe_busy", 64'(bus.busy), 64'd0);
    check("rst_readdata", 64'(bus.readdata), 64'd0);
    bus_read(8'd0, d);
    check("rst_reg_a", 64'(d), 64'd0);
    bus_read(8'd3, d);
    check("rst_status", 64'(d), 64'd0);

    // read-only and write-only registers
    bus_write(8'd3, 32'hFF);
    bus_read(8'd3, d);
    check("status_write_ignored", 64'(d), 64'd0);
    bus_write(8'd2, 32'd0);
    bus_read(8'd2, d);
    check("ctrl_reads_zero", 64'(d), 64'd0);

    // same-cycle read and write of A
    bus_write(8'd0, 32'h11);
    bus.address = 8'd0;
    bus.writedata = 32'h22;
    bus.write = 1'b1;
    bus.read = 1'b1;
    @(negedge csi_clk);
    bus.write = 1'b0;
    bus.read = 1'b0;
    check("rw_same_cycle_old", 64'(bus.readdata), 64'h11);
    bus_read(8'd0, d);
    check("rw_same_cycle_new", 64'(d), 64'h22);

    // directed table
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].acc, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_coe_R", i), 64'(bus.result), 64'(vecs[i].exp_r));
      bus_read(8'd4, d);
      check($sformatf("vec%0d_result_reg", i), 64'(d), 64'(vecs[i].exp_r));
      bus_read(8'd3, d);
      check($sformatf("vec%0d_status", i), 64'(d), 64'(vecs[i].exp_status));
      bus_read(8'd1, d);
      check($sformatf("vec%0d_reg_b", i), 64'(d), 64'(vecs[i].b));
    end

    // writes and a second START during CALC are ignored
    bus_write(8'd0, 32'd3);
    bus_write(8'd1, 32'd5);
    done_pulses = 0;
    bus_write(8'd2, 32'd1);
    bus_write(8'd0, 32'd7);
    bus_write(8'd2, 32'd1);
    bus_read(8'd0, d);
    check("busy_read_a", 64'(d), 64'd3);
    repeat (45) @(negedge csi_clk);
    check("busy_done_pulses", 64'(done_pulses), 64'd1);
    check("busy_coe_R", 64'(bus.result), 64'd30);
    bus_read(8'd0, d);
    check("busy_reg_a_kept", 64'(d), 64'd3);
    model_prev = 32'd30;

    // randomized operations against the reference model
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        ra = 32'($urandom_range(0, 255));
        rb = 32'($urandom_range(0, 255));
      end else begin
        ra = $urandom;
        rb = $urandom;
      end
      racc = 1'($urandom_range(0, 1));
      m = ref_mac(ra, rb, racc, model_prev);
      run_op(ra, rb, racc, $sformatf("rnd%0d", i));
      check($sformatf("rnd%0d_coe_R", i), 64'(bus.result), 64'(m[31:0]));
      bus_read(8'd3, d);
      check($sformatf("rnd%0d_status", i), 64'(d), 64'({m[32], 2'b10}));
      model_prev = m[31:0];
    end

    // reset in the middle of a calculation
    run_op(32'd3, 32'd5, 1'b0, "pre_rst");
    check("pre_rst_coe_R", 64'(bus.result), 64'd30);
    bus_write(8'd0, 32'd5);
    bus_write(8'd1, 32'd7);
    bus_read(8'd0, d);
    check("pre_rst_readdata", 64'(d), 64'd5);
    bus_write(8'd2, 32'd1);
    repeat (10) @(negedge csi_clk);
    done_pulses = 0;
    rsi_rst_n = 1'b0;
    #1;
    check("midrst_coe_R", 64'(bus.result), 64'd0);
    check("midrst_coe_done", 64'(bus.done), 64'd0);
    check("midrst_coe_busy", 64'(bus.busy), 64'd0);
    check("midrst_readdata", 64'(bus.readdata), 64'd0);
    @(negedge csi_clk);
    rsi_rst_n = 1'b1;
    repeat (40) @(negedge csi_clk);
    check("midrst_no_done", 64'(done_pulses), 64'd0);
    bus_read(8'd0, d);
    check("midrst_reg_a", 64'(d), 64'd0);
    bus_read(8'd3, d);
    check("midrst_status", 64'(d), 64'd0);
    run_op(32'd2, 32'd2, 1'b0, "post_rst");
    check("post_rst_coe_R", 64'(bus.result), 64'd8);

    // unmapped and RESULT reads
    bus_read(8'd9, d);
    check("read_unmapped", 64'(d), 64'd0);
    bus_read(8'd4, d);
    check("read_result", 64'(d), 64'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
